// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/ack, memory-side and status signals of the IF/DM memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// datapath and memory that surround it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    // data load/store port
    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    // shared memory port
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // status
    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output grant, busy
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  grant, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory port between instruction fetch (IF)
// and data load/store (DM).
// Each access runs IDLE -> BUSY (WAIT_CYC+1 cycles) -> ACK -> IDLE.
// Optional macro ARB_RR_EN selects a round-robin tie-break in place of fixed DM priority.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int CNT_W = 4;   // WAIT_CYC is limited to 1..15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              take;      // start an access at this edge
    logic              take_dm;   // the access being started belongs to DM
    logic              done;      // last BUSY cycle, read data is valid now
    logic              pick_dm;   // arbitration result if both are requesting
    logic              is_wr;     // latched write flag of the current access

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              if_ack;
    logic              dm_ack;
    logic [1:0]        grant;

`ifdef ARB_RR_EN
    // 0 = DM was granted last, 1 = IF was granted last. The reset value 0 means
    // DM, so the first tie after reset goes to IF.
    logic last_grant;

    // tie goes to the port that was not granted last
    always_comb begin
        pick_dm = bus.dm_req & (~bus.if_req | last_grant);
    end

    // remember the owner of every new grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= 1'b0;
        else if (take)
            last_grant <= ~take_dm;
    end
`else
    // fixed priority: DM wins any tie
    always_comb begin
        pick_dm = bus.dm_req;
    end
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state and per-edge control strobes
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        take_dm   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    take      = 1'b1;
                    take_dm   = pick_dm;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;   // requests are ignored here
            default: state_nxt = IDLE;
        endcase
    end

    // latency counter: loaded on grant, counts down through BUSY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (take)
            cnt <= CNT_W'(WAIT_CYC);
        else if (state == BUSY && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // memory-side registers: latch the winner's request; mem_en and mem_we pulse once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            is_wr     <= 1'b0;
        end else begin
            mem_en <= take;
            mem_we <= take & take_dm & bus.dm_we;
            if (take) begin
                is_wr     <= take_dm & bus.dm_we;
                mem_be    <= take_dm ? bus.dm_be    : 4'b1111;
                mem_addr  <= take_dm ? bus.dm_addr  : bus.if_addr;
                mem_wdata <= take_dm ? bus.dm_wdata : '0;
            end
        end
    end

    // owner indication: set on grant and held through ACK
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            grant <= 2'b00;
        else if (take)
            grant <= take_dm ? 2'b10 : 2'b01;
        else if (state == ACK)
            grant <= 2'b00;
    end

    // capture read data into the owner's register and raise its one-cycle ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata <= '0;
            dm_rdata <= '0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
        end else begin
            if_ack <= done & grant[0];
            dm_ack <= done & grant[1];
            if (done && !is_wr) begin
                if (grant[1])
                    dm_rdata <= bus.mem_rdata;
                else
                    if_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_be    = mem_be;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.if_rdata  = if_rdata;
    assign bus.dm_rdata  = dm_rdata;
    assign bus.if_ack    = if_ack;
    assign bus.dm_ack    = dm_ack;
    assign bus.grant     = grant;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by random IF/DM traffic.
// The bench checks every cycle against a transaction-level reference model.
// The model treats an access granted at the edge ending cycle c as follows:
//   mem_en in cycle c+1, ack in cycle c+2+WAIT_CYC, next sampling edge at the end of c+3+WAIT_CYC.
module tb_mem_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WAIT_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // memory contents: one preloaded word, everything else a hash of the address
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2010_0005;
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // ---------------- reference model state ----------------
    int          idle_from = 0;     // earliest cycle whose closing edge may grant
    int          en_cyc    = -100;
    int          ack_cyc   = -100;
    bit          m_dm      = 1'b0;  // current owner is DM
    bit          m_wr      = 1'b0;
    logic [3:0]  m_be      = '0;
    logic [31:0] m_addr    = '0;
    logic [31:0] m_wdata   = '0;
    logic [31:0] exp_if_rd = '0;
    logic [31:0] exp_dm_rd = '0;
    bit          last_if   = 1'b0;  // round-robin memory: IF was granted last
    logic [1:0]  dut_glog[$];       // DUT grant seen at each mem_en

    bit          hist_en[32];
    logic [31:0] hist_addr[32];
    bit          in_win;
    bit          pick_dm;

    // memory model, per-cycle checking and arbitration model, all at the falling edge
    always @(negedge clk) begin
        hist_en[cyc % 32]   = bus.mem_en;
        hist_addr[cyc % 32] = bus.mem_addr;
        if (cyc >= WAIT_CYC && hist_en[(cyc - WAIT_CYC) % 32])
            bus.mem_rdata = mem_read(hist_addr[(cyc - WAIT_CYC) % 32]);
        else
            bus.mem_rdata = $urandom;
        if (bus.mem_en) dut_glog.push_back(bus.grant);

        if (!rst) begin
            chk("rst_mem_en",   bus.mem_en,    0);
            chk("rst_mem_we",   bus.mem_we,    0);
            chk("rst_mem_be",   bus.mem_be,    0);
            chk("rst_mem_addr", bus.mem_addr,  0);
            chk("rst_mem_wd",   bus.mem_wdata, 0);
            chk("rst_if_rdata", bus.if_rdata,  0);
            chk("rst_dm_rdata", bus.dm_rdata,  0);
            chk("rst_if_ack",   bus.if_ack,    0);
            chk("rst_dm_ack",   bus.dm_ack,    0);
            chk("rst_grant",    bus.grant,     0);
            chk("rst_busy",     bus.busy,      0);
            idle_from = 0;
            en_cyc    = -100;
            ack_cyc   = -100;
            exp_if_rd = '0;
            exp_dm_rd = '0;
            last_if   = 1'b0;
        end else begin
            if (cyc == ack_cyc && !m_wr) begin
                if (m_dm) exp_dm_rd = mem_read(m_addr);
                else      exp_if_rd = mem_read(m_addr);
            end
            in_win = (cyc >= en_cyc) && (cyc <= ack_cyc);
            chk("mem_en", bus.mem_en, cyc == en_cyc);
            chk("mem_we", bus.mem_we, (cyc == en_cyc) && m_wr);
            if (cyc == en_cyc) begin
                chk("mem_addr", bus.mem_addr, m_addr);
                chk("mem_be",   bus.mem_be,   m_be);
                if (m_wr) chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            chk("grant",    bus.grant,    in_win ? (m_dm ? 2'b10 : 2'b01) : 2'b00);
            chk("busy",     bus.busy,     in_win);
            chk("if_ack",   bus.if_ack,   (cyc == ack_cyc) && !m_dm);
            chk("dm_ack",   bus.dm_ack,   (cyc == ack_cyc) &&  m_dm);
            chk("if_rdata", bus.if_rdata, exp_if_rd);
            chk("dm_rdata", bus.dm_rdata, exp_dm_rd);

            // arbitration decision taken at the edge that ends this cycle
            if (cyc >= idle_from && (bus.if_req || bus.dm_req)) begin
`ifdef ARB_RR_EN
                pick_dm = bus.dm_req && (!bus.if_req || last_if);
`else
                pick_dm = bus.dm_req;
`endif
                last_if   = !pick_dm;
                m_dm      = pick_dm;
                m_wr      = pick_dm && bus.dm_we;
                m_be      = pick_dm ? bus.dm_be : 4'b1111;
                m_addr    = pick_dm ? bus.dm_addr : bus.if_addr;
                m_wdata   = bus.dm_wdata;
                en_cyc    = cyc + 1;
                ack_cyc   = cyc + 2 + WAIT_CYC;
                idle_from = cyc + 3 + WAIT_CYC;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit dm, input bit v);
        if (dm) bus.dm_req = v;
        else    bus.if_req = v;
    endtask

    task automatic rand_fields(input bit dm);
        if (dm) begin
            bus.dm_addr  = $urandom;
            bus.dm_wdata = $urandom;
            bus.dm_we    = 1'($urandom_range(0, 1));
            bus.dm_be    = 4'($urandom);
        end else begin
            bus.if_addr = $urandom;
        end
    endtask

    // wait for n acks; drop the acked port's request unless hold is set
    task automatic serve(input int n, input bit hold);
        int got = 0;
        for (int t = 0; t < 300 && got < n; t++) begin
            tick();
            if (cyc == ack_cyc) begin
                got++;
                if (!hold) set_req(m_dm, 1'b0);
            end
        end
        chk("serve_count", got, n);
    endtask

    task automatic rand_phase(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                bit dm;
                bit cur;
                dm  = (p == 1);
                cur = dm ? bus.dm_req : bus.if_req;
                if (cyc == ack_cyc && m_dm == dm) begin
                    if ($urandom_range(0, 1) == 0) set_req(dm, 1'b0);
                    else rand_fields(dm);           // keep req: back-to-back access
                end else if (!cur) begin
                    if ($urandom_range(0, 3) == 0) begin
                        rand_fields(dm);
                        set_req(dm, 1'b1);
                    end
                end else if (cyc >= en_cyc && cyc < ack_cyc && m_dm == dm &&
                             $urandom_range(0, 2) == 0) begin
                    rand_fields(dm);                // must not disturb the latched access
                end
            end
        end
        set_req(1'b0, 1'b0);
        set_req(1'b1, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [1:0] exp_g;
        bus.if_req = 0; bus.if_addr = '0;
        bus.dm_req = 0; bus.dm_we = 0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rdata = '0;
        #1 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // IF read of the preloaded word
        bus.if_addr = 32'h0040_0000;
        set_req(1'b0, 1'b1);
        serve(1, 1'b0);
        chk("t1_if_rdata", bus.if_rdata, 32'h2010_0005);
        tick();

        // DM write: no read data update
        bus.dm_addr = 32'h1001_0000; bus.dm_wdata = 32'h1234_5678;
        bus.dm_be = 4'b1111; bus.dm_we = 1'b1;
        set_req(1'b1, 1'b1);
        serve(1, 1'b0);
        chk("t2_dm_rdata", bus.dm_rdata, 32'h0);
        tick();

        // simultaneous requests, both served
        bus.dm_we = 1'b0; bus.dm_addr = 32'h1001_0010; bus.if_addr = 32'h0040_0004;
        set_req(1'b0, 1'b1);
        set_req(1'b1, 1'b1);
        serve(2, 1'b0);
        repeat (2) tick();

        // both requests held for four accesses
        dut_glog.delete();
        set_req(1'b0, 1'b1);
        set_req(1'b1, 1'b1);
        serve(4, 1'b1);
        set_req(1'b0, 1'b0);
        set_req(1'b1, 1'b0);
        repeat (3) tick();
        chk("t4_glog_len", dut_glog.size(), 4);
        for (int i = 0; i < 4 && i < dut_glog.size(); i++) begin
`ifdef ARB_RR_EN
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b10;
`endif
            chk("t4_grant", dut_glog[i], exp_g);
        end

        // reset in the middle of a DM read, request held across it
        bus.dm_we = 1'b0; bus.dm_addr = 32'h1001_0040;
        set_req(1'b1, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("t5_mem_en", bus.mem_en, 0);
        chk("t5_busy",   bus.busy,   0);
        chk("t5_grant",  bus.grant,  0);
        chk("t5_addr",   bus.mem_addr, 0);
        tick();
        tick();
        rst = 1'b1;
        serve(1, 1'b0);
        tick();

        // request raised during another port's ACK cycle
        bus.dm_we = 1'b0; bus.dm_addr = 32'h1001_0080;
        set_req(1'b1, 1'b1);
        for (int t = 0; t < 50; t++) begin
            tick();
            if (cyc == ack_cyc) break;
        end
        chk("t6_in_ack", cyc, ack_cyc);
        set_req(1'b1, 1'b0);
        bus.if_addr = 32'h0040_0100;
        set_req(1'b0, 1'b1);
        serve(1, 1'b0);
        tick();

        rand_phase(800);
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
